// File: rtl/simproc_dbg_ctrl.sv
// -----------------------------------------------------------------------------
// simproc_dbg_ctrl
//
// Host debug controller for a small 8-bit core. It takes command bytes from a
// host stream and returns response bytes on a second stream. It can read and
// write the core RAM while the core is halted, set the PC, run, stop, and
// single-step the core.
//
// Optional feature (macro SIMPROC_DBG_ICOUNT_EN): a 16-bit count of retired
// instructions (cycles with done=1). COUNT returns it low byte first. Without
// the macro the counter is left out and COUNT gets the unknown-opcode answer.
//
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   host_cmd_valid/ready/data[7:0]    host command byte stream (in)
//   host_rsp_valid/ready/data[7:0]    response byte stream (out)
//   cpu_mem_addr/din[7:0], cpu_mem_we core memory request
//   cpu_mem_dout[7:0]                 read data to the core (= ram_dout)
//   ram_addr/din[7:0], ram_we         arbitrated RAM port
//   ram_dout[7:0]                     RAM read data, combinational from ram_addr
//   pc_set_val[7:0], pc_set_wr, run   core debug controls
//   halt, done                        core status
// -----------------------------------------------------------------------------
module simproc_dbg_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_cmd_valid,
  output logic       host_cmd_ready,
  input  logic [7:0] host_cmd_data,
  output logic       host_rsp_valid,
  input  logic       host_rsp_ready,
  output logic [7:0] host_rsp_data,
  input  logic [7:0] cpu_mem_addr,
  input  logic [7:0] cpu_mem_din,
  input  logic       cpu_mem_we,
  output logic [7:0] cpu_mem_dout,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_din,
  output logic       ram_we,
  input  logic [7:0] ram_dout,
  output logic [7:0] pc_set_val,
  output logic       pc_set_wr,
  output logic       run,
  input  logic       halt,
  input  logic       done
);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_SETPC = 8'h03;
  localparam logic [7:0] OP_RUN   = 8'h04;
  localparam logic [7:0] OP_STOP  = 8'h05;
  localparam logic [7:0] OP_STEP  = 8'h06;
`ifdef SIMPROC_DBG_ICOUNT_EN
  localparam logic [7:0] OP_COUNT = 8'h07;
`endif

  localparam logic [7:0] RSP_OK   = 8'hA5;
  localparam logic [7:0] RSP_BUSY = 8'hEB;
  localparam logic [7:0] RSP_BAD  = 8'hEE;

  typedef enum logic [2:0] {
    IDLE, ARG1, ARG2, EXEC, RSP, WAIT_HALT, WAIT_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] opcode_q;
  logic [7:0] addr_q;     // first argument (address or PC value)
  logic [7:0] data_q;     // second argument (write data)
  logic [7:0] rsp_q;
  logic       run_q;
  logic [7:0] pc_val_q;
  logic       rsp_last;   // the byte on host_rsp_data is the final one

  logic cmd_fire, rsp_fire;
  logic needs_halt, reject, do_exec;
  logic ram_we_ctl, step_pulse, core_owns;

  // Number of argument bytes that follow an opcode.
  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      OP_WRITE:          arg_count = 2'd2;
      OP_READ, OP_SETPC: arg_count = 2'd1;
      default:           arg_count = 2'd0;
    endcase
  endfunction

  assign cmd_fire = host_cmd_valid && host_cmd_ready;
  assign rsp_fire = host_rsp_valid && host_rsp_ready;

  // Commands that touch RAM or the PC, or move the core, only run while the
  // core is parked; otherwise they are answered busy with no side effect.
  assign needs_halt = (opcode_q == OP_WRITE) || (opcode_q == OP_READ) ||
                      (opcode_q == OP_SETPC) || (opcode_q == OP_STEP);
  assign reject     = needs_halt && (run_q || !halt);
  assign do_exec    = (state == EXEC) && !reject;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples values from before the clock edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (cmd_fire) state_nxt = (arg_count(host_cmd_data) == 2'd0) ? EXEC : ARG1;
      ARG1:
        if (cmd_fire) state_nxt = (arg_count(opcode_q) == 2'd2) ? ARG2 : EXEC;
      ARG2:
        if (cmd_fire) state_nxt = EXEC;
      EXEC:
        if (reject)                   state_nxt = RSP;
        else if (opcode_q == OP_STOP) state_nxt = halt ? RSP : WAIT_HALT;
        else if (opcode_q == OP_STEP) state_nxt = WAIT_DONE;
        else                          state_nxt = RSP;
      RSP:
        if (rsp_fire && rsp_last) state_nxt = IDLE;
      WAIT_HALT:
        if (halt) state_nxt = RSP;
      WAIT_DONE:
        if (done) state_nxt = RSP;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    host_cmd_ready = 1'b0;
    host_rsp_valid = 1'b0;
    ram_we_ctl     = 1'b0;
    pc_set_wr      = 1'b0;
    step_pulse     = 1'b0;
    case (state)
      IDLE, ARG1, ARG2: host_cmd_ready = 1'b1;
      RSP:              host_rsp_valid = 1'b1;
      EXEC: begin
        ram_we_ctl = do_exec && (opcode_q == OP_WRITE);
        pc_set_wr  = do_exec && (opcode_q == OP_SETPC);
        step_pulse = do_exec && (opcode_q == OP_STEP);
      end
      default: ;
    endcase
  end

  // A step raises run for the EXEC cycle only; run_q holds the RUN/STOP level.
  assign run       = run_q || step_pulse;
  assign core_owns = run || !halt;

  assign ram_addr      = core_owns ? cpu_mem_addr : addr_q;
  assign ram_din       = core_owns ? cpu_mem_din  : data_q;
  assign ram_we        = core_owns ? cpu_mem_we   : ram_we_ctl;
  assign cpu_mem_dout  = ram_dout;
  assign host_rsp_data = rsp_q;
  // The new PC value is already visible during the write pulse.
  assign pc_set_val    = pc_set_wr ? addr_q : pc_val_q;

`ifdef SIMPROC_DBG_ICOUNT_EN
  logic [15:0] cnt_q;
  logic [7:0]  rsp_hi_q;
  logic        rsp_more_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_q <= 16'h0000;
    else if (done) cnt_q <= cnt_q + 16'h0001;
  end

  assign rsp_last = !rsp_more_q;
`else
  assign rsp_last = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Datapath: argument capture, command side effects, response byte
  // ---------------------------------------------------------------------------
  // NOTE: the argument and response registers are reset as well, so nothing
  // from an aborted command can leak out after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q   <= 8'h00;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      rsp_q      <= 8'h00;
      run_q      <= 1'b0;
      pc_val_q   <= 8'h00;
`ifdef SIMPROC_DBG_ICOUNT_EN
      rsp_hi_q   <= 8'h00;
      rsp_more_q <= 1'b0;
`endif
    end else begin
      if (cmd_fire) begin
        case (state)
          IDLE:    opcode_q <= host_cmd_data;
          ARG1:    addr_q   <= host_cmd_data;
          ARG2:    data_q   <= host_cmd_data;
          default: ;
        endcase
      end

      if (state == EXEC) begin
`ifdef SIMPROC_DBG_ICOUNT_EN
        rsp_more_q <= 1'b0;
`endif
        if (reject) begin
          rsp_q <= RSP_BUSY;
        end else begin
          case (opcode_q)
            OP_WRITE, OP_STEP: rsp_q <= RSP_OK;
            OP_READ:           rsp_q <= ram_dout;
            OP_SETPC: begin
              pc_val_q <= addr_q;
              rsp_q    <= RSP_OK;
            end
            OP_RUN: begin
              run_q <= 1'b1;
              rsp_q <= RSP_OK;
            end
            OP_STOP: begin
              run_q <= 1'b0;
              rsp_q <= RSP_OK;
            end
`ifdef SIMPROC_DBG_ICOUNT_EN
            // Both halves are captured in the same cycle so the pair is
            // consistent even if done keeps pulsing during the response.
            OP_COUNT: begin
              rsp_q      <= cnt_q[7:0];
              rsp_hi_q   <= cnt_q[15:8];
              rsp_more_q <= 1'b1;
            end
`endif
            default: rsp_q <= RSP_BAD;
          endcase
        end
      end

`ifdef SIMPROC_DBG_ICOUNT_EN
      if (state == RSP && rsp_fire && rsp_more_q) begin
        rsp_q      <= rsp_hi_q;
        rsp_more_q <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: doc/simproc_dbg_ctrl.md
SIMPROC_DBG_CTRL -- requirements
Module: simproc_dbg_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port host_cmd_valid/host_cmd_ready/host_cmd_data, in/out/in, 1/1/8, host command byte stream with valid/ready handshake.
REQ-004 SHALL have port host_rsp_valid/host_rsp_ready/host_rsp_data, out/in/out, 1/1/8, response byte stream with valid/ready handshake.
REQ-005 SHALL have port cpu_mem_addr/cpu_mem_din/cpu_mem_we, input, 8/8/1, core memory request.
REQ-006 SHALL have port cpu_mem_dout, output, 8, read data to the core, always equal to ram_dout.
REQ-007 SHALL have port ram_addr/ram_din/ram_we, output, 8/8/1, arbitrated RAM port.
REQ-008 SHALL have port ram_dout, input, 8, RAM read data, combinational from ram_addr in the same cycle.
REQ-009 SHALL have port pc_set_val/pc_set_wr/run, output, 8/1/1, core debug controls; halt/done, input, 1/1, core status.

Function
REQ-010 SHALL accept a byte only when host_cmd_valid and host_cmd_ready are both 1; a response byte transfers only when host_rsp_valid and host_rsp_ready are both 1, with host_rsp_data held stable while valid and not ready.
REQ-011 SHALL use FSM states IDLE, ARG1, ARG2, EXEC, RSP, WAIT_HALT, WAIT_DONE; host_cmd_ready SHALL be 1 only in IDLE, ARG1, and ARG2.
REQ-012 SHALL decode command opcodes: 0x01 WRITE(addr,data), 0x02 READ(addr), 0x03 SETPC(val), 0x04 RUN, 0x05 STOP, 0x06 STEP, 0x07 COUNT; each command yields its response bytes before the next opcode is accepted.
REQ-013 SHALL, for any other opcode, take no arguments and respond 0xEE.
REQ-014 SHALL give the RAM port to the core (ram_* = cpu_mem_*) while run=1 or halt=0, and to the controller otherwise, with ram_we=0 except in the WRITE EXEC cycle.
REQ-015 SHALL reject WRITE/READ/SETPC/STEP with response 0xEB (busy) and no side effect when run=1 or halt=0 in EXEC; arguments are still consumed.
REQ-016 SHALL, for WRITE, drive ram_we=1 for exactly one cycle with the captured addr/data, then respond 0xA5.
REQ-017 SHALL, for READ, drive ram_addr=addr in EXEC, register ram_dout, and respond with that byte.
REQ-018 SHALL, for SETPC, pulse pc_set_wr for one cycle with pc_set_val=val, then respond 0xA5.
REQ-019 SHALL, for RUN, set run=1 and hold it, then respond 0xA5; RUN while already running responds 0xA5 with no change.
REQ-020 SHALL, for STOP, clear run, enter WAIT_HALT until halt=1, then respond 0xA5; if already halted, respond next cycle.
REQ-021 SHALL, for STEP, assert run for exactly one cycle, enter WAIT_DONE until a done pulse arrives, then respond 0xA5.
REQ-022 SHALL drive pc_set_val to the last SETPC value at all times.

Reset
REQ-023 SHALL on rst_n=0 immediately force: state IDLE; run, pc_set_wr, ram_we, and host_rsp_valid 0; host_cmd_ready 1 after release; pc_set_val 0x00; counter 0; partial commands discarded.
REQ-024 SHALL abort a reset asserted mid-command without emitting any response byte.

Configuration
REQ-025 SHALL use macro SIMPROC_DBG_ICOUNT_EN: when defined, a 16-bit counter increments on every cycle done=1 (wraps 0xFFFF->0x0000), and COUNT responds with the low byte then the high byte, sampled atomically in EXEC.
REQ-026 SHALL, when SIMPROC_DBG_ICOUNT_EN is undefined, omit the counter, and opcode 0x07 SHALL respond 0xEE.

Verification
REQ-027 SHALL pass: with core halted, WRITE 0x10,0x3C then READ 0x10 -> responses 0xA5, 0x3C; ram_we high exactly 1 cycle.
REQ-028 SHALL pass: SETPC 0x20 -> pc_set_wr 1-cycle pulse with pc_set_val=0x20, response 0xA5.
REQ-029 SHALL pass: STEP with halt=1 -> run high 1 cycle; model asserts done 3 cycles later -> single 0xA5 after done.
REQ-030 SHALL pass: RUN, then READ 0x00 while halt=0 -> 0xA5, then 0xEB; STOP -> 0xA5 only after halt returns 1.
REQ-031 SHALL pass: opcode 0x7F -> 0xEE; host_rsp_ready held 0 for 5 cycles -> data stable and single transfer.
REQ-032 SHALL pass: with SIMPROC_DBG_ICOUNT_EN, 0x0102 done pulses then COUNT -> 0x02, 0x01; rst_n low mid-WRITE -> no response and no ram_we.
